cam_pixel_serializer: RTL and testbench

- Parametrised successor to the camera capture path: samples the sensor bus (pclk/href/vsync/pixdata) in the system clock domain.
- Assembles multi-byte pixels and repacks them per a run-time colour mode, with optional horizontal decimation.
- Buffers pixels in a FIFO and shifts them out on an externally clocked serial line.
- Sits between the sensor pins and the host serial link; replaces the fixed 12-bit capture/transmit pair.

---
 rtl/cam_pkg.sv | 32 +++
 rtl/cam_pix_fifo.sv | 49 ++++
 rtl/cam_pixel_serializer.sv | 200 ++++++++++++++++++++
 tb/tb_cam_pixel_serializer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types for the camera capture/serial path: colour modes, capture states, serial start bit, pixel repack.
package cam_pkg;

   typedef enum logic [1:0] {
      MODE_RAW     = 2'd0,
      MODE_565_444 = 2'd1,
      MODE_IL444   = 2'd2,
      MODE_TEST    = 2'd3
   } cam_mode_t;

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      ACTIVE     = 1'b1
   } cap_state_t;

   localparam logic START_BIT = 1'b1;

   // Returns a 32-bit word; the caller truncates to its pixel width. Unknown modes fall back to raw.
   function automatic logic [31:0] repack(input cam_mode_t mode, input logic [31:0] raw);
      logic [31:0] res;
      res = raw;
      case (mode)
         MODE_565_444: res = {20'd0, raw[15:12], raw[10:7], raw[4:1]};
         MODE_IL444:   res = {20'd0, raw[11], raw[8], raw[5], raw[2],
                                     raw[10], raw[7], raw[4], raw[1],
                                     raw[9],  raw[6], raw[3], raw[0]};
         default:      res = raw;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/cam_pix_fifo.sv
// Synchronous pixel FIFO with first-word-fall-through read; push is refused only when full without a same-cycle pop.
// Zero-latency full/empty flags; a push and pop together on a full FIFO both succeed.
module cam_pix_fifo
   import cam_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wr_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rd_dat,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_rd_dat  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/cam_pixel_serializer.sv
// Sensor bus capture -> pixel repack/decimate -> FIFO -> serck-paced serial shifter; pix_valid one cycle after the pclk edge.
// FIFO full drops pixels and sets sticky overflow. CAM_TEST_PATTERN_EN makes mode 3 emit {line_cnt, pixel index}.
module cam_pixel_serializer
   import cam_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int PIX_W         = 12,
   parameter int FIFO_DEPTH    = 16,
   parameter int CNT_W         = 10,
   parameter int DEC_W         = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pclk,
   input  logic              href,
   input  logic              vsync,
   input  logic [DATA_W-1:0] pixdata,
   input  logic              serck,
   input  logic [1:0]        mode,
   input  logic [DEC_W-1:0]  decim,
   output logic              ser_out,
   output logic              ser_busy,
   output logic              pix_valid,
   output logic [PIX_W-1:0]  pix_data,
   output logic [CNT_W-1:0]  line_cnt,
   output logic              overflow,
   input  logic              clr_ovf
);

   localparam int         ASM_W     = DATA_W * BYTES_PER_PIX;
   localparam int         BIT_W     = $clog2(PIX_W + 1);
   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PIX - 1);

   logic r_pclk_s1, r_pclk_s2, r_pclk_s3;
   logic r_href_s1, r_href_s2, r_href_s3;
   logic r_vs_s1, r_vs_s2, r_vs_s3;
   logic r_serck_s1, r_serck_s2, r_serck_s3;
   logic [DATA_W-1:0] r_pix_s1, r_pix_s2;

   cap_state_t r_state, w_state_nxt;
   logic [ASM_W-1:0] r_asm;
   logic [1:0]       r_byte_cnt;
   logic [DEC_W-1:0] r_dec_cnt;
   logic [CNT_W-1:0] r_line_cnt;
   logic             r_pix_valid;
   logic [PIX_W-1:0] r_pix_data;
   logic             r_ovf;
   logic             r_busy;
   logic [PIX_W:0]   r_shift;
   logic [BIT_W-1:0] r_bit_cnt;

   logic w_pclk_rise, w_href_rise, w_href_fall, w_vs_rise, w_vs_fall, w_serck_rise;
   logic w_sample, w_complete, w_keep, w_push, w_pop, w_full, w_empty;
   logic [ASM_W-1:0] w_asm_nxt;
   logic [DEC_W-1:0] w_dec_cur;
   logic [PIX_W-1:0] w_repacked, w_fifo_rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {r_pclk_s1, r_pclk_s2, r_pclk_s3}    <= '0;
         {r_href_s1, r_href_s2, r_href_s3}    <= '0;
         {r_vs_s1, r_vs_s2, r_vs_s3}          <= '0;
         {r_serck_s1, r_serck_s2, r_serck_s3} <= '0;
         r_pix_s1 <= '0;
         r_pix_s2 <= '0;
      end else begin
         {r_pclk_s3, r_pclk_s2, r_pclk_s1}    <= {r_pclk_s2, r_pclk_s1, pclk};
         {r_href_s3, r_href_s2, r_href_s1}    <= {r_href_s2, r_href_s1, href};
         {r_vs_s3, r_vs_s2, r_vs_s1}          <= {r_vs_s2, r_vs_s1, vsync};
         {r_serck_s3, r_serck_s2, r_serck_s1} <= {r_serck_s2, r_serck_s1, serck};
         r_pix_s2 <= r_pix_s1;
         r_pix_s1 <= pixdata;
      end
   end

   assign w_pclk_rise  = r_pclk_s2 & ~r_pclk_s3;
   assign w_href_rise  = r_href_s2 & ~r_href_s3;
   assign w_href_fall  = ~r_href_s2 & r_href_s3;
   assign w_vs_rise    = r_vs_s2 & ~r_vs_s3;
   assign w_vs_fall    = ~r_vs_s2 & r_vs_s3;
   assign w_serck_rise = r_serck_s2 & ~r_serck_s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= WAIT_FRAME;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sample    = 1'b0;
      case (r_state)
         WAIT_FRAME: if (w_vs_fall) w_state_nxt = ACTIVE;
         ACTIVE: begin
            if (w_vs_rise) w_state_nxt = WAIT_FRAME;
            else           w_sample    = w_pclk_rise & r_href_s2;
         end
         default: w_state_nxt = WAIT_FRAME;
      endcase
   end

   assign w_complete = w_sample & (r_byte_cnt == LAST_BYTE);
   assign w_asm_nxt  = ASM_W'({r_asm, r_pix_s2});
   assign w_dec_cur  = w_href_rise ? '0 : r_dec_cnt;
   assign w_keep     = w_complete & (w_dec_cur == '0);
   assign w_pop      = ~r_busy & ~w_empty;
   assign w_push     = w_keep & (~w_full | w_pop);

`ifdef CAM_TEST_PATTERN_EN
   logic [CNT_W-1:0] r_pix_idx;
   logic [CNT_W-1:0] w_idx_cur;

   assign w_idx_cur  = w_href_rise ? '0 : r_pix_idx;
   assign w_repacked = (mode == MODE_TEST) ? PIX_W'({r_line_cnt, w_idx_cur})
                                           : PIX_W'(repack(cam_mode_t'(mode), 32'(w_asm_nxt)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   r_pix_idx <= '0;
      else if (r_state == WAIT_FRAME) r_pix_idx <= '0;
      else if (w_complete)          r_pix_idx <= w_idx_cur + CNT_W'(1);
      else if (w_href_rise)         r_pix_idx <= '0;
   end
`else
   assign w_repacked = PIX_W'(repack(cam_mode_t'(mode), 32'(w_asm_nxt)));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_asm       <= '0;
         r_byte_cnt  <= '0;
         r_dec_cnt   <= '0;
         r_line_cnt  <= '0;
         r_pix_valid <= 1'b0;
         r_pix_data  <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_pix_valid <= w_push;
         if (w_push) r_pix_data <= w_repacked;
         if (w_keep && !w_push) r_ovf <= 1'b1;
         else if (clr_ovf)      r_ovf <= 1'b0;

         if (r_state == WAIT_FRAME) begin
            r_byte_cnt <= '0;
            r_dec_cnt  <= '0;
            r_line_cnt <= '0;
         end else begin
            if (w_sample) begin
               r_asm      <= w_asm_nxt;
               r_byte_cnt <= w_complete ? 2'd0 : r_byte_cnt + 2'd1;
            end
            // A line end throws away any half-assembled pixel.
            if (w_href_fall) begin
               r_byte_cnt <= '0;
               if (r_line_cnt != '1) r_line_cnt <= r_line_cnt + CNT_W'(1);
            end
            if (w_complete)       r_dec_cnt <= (w_dec_cur == decim) ? '0 : w_dec_cur + DEC_W'(1);
            else if (w_href_rise) r_dec_cnt <= '0;
         end
      end
   end

   cam_pix_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_push   (w_push),
      .i_wr_dat (w_repacked),
      .i_pop    (w_pop),
      .o_rd_dat (w_fifo_rd),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   // Start bit is on the line from the pop; each serck edge then exposes the next bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy    <= 1'b0;
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (w_pop) begin
         r_busy    <= 1'b1;
         r_shift   <= {START_BIT, w_fifo_rd};
         r_bit_cnt <= BIT_W'(PIX_W);
      end else if (r_busy && w_serck_rise) begin
         if (r_bit_cnt == '0) begin
            r_busy <= 1'b0;
         end else begin
            r_shift   <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt - BIT_W'(1);
         end
      end
   end

   assign ser_out   = r_busy & r_shift[PIX_W];
   assign ser_busy  = r_busy;
   assign pix_valid = r_pix_valid;
   assign pix_data  = r_pix_data;
   assign line_cnt  = r_line_cnt;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_cam_pixel_serializer.sv
// Directed bench for cam_pixel_serializer: reset, colour modes, decimation, overflow, serial framing, vsync abort.
module tb_cam_pixel_serializer;
   import cam_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pclk = 1'b0, href = 1'b0, vsync = 1'b0, serck = 1'b0, clr_ovf = 1'b0;
   logic [7:0]  pixdata = '0;
   logic [1:0]  mode = '0;
   logic [2:0]  decim = '0;
   logic        ser_out, ser_busy, pix_valid, overflow;
   logic [11:0] pix_data;
   logic [9:0]  line_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;

   always #5 clk = ~clk;

   cam_pixel_serializer dut (
      .clk(clk), .rst_n(rst_n), .pclk(pclk), .href(href), .vsync(vsync), .pixdata(pixdata),
      .serck(serck), .mode(mode), .decim(decim), .ser_out(ser_out), .ser_busy(ser_busy),
      .pix_valid(pix_valid), .pix_data(pix_data), .line_cnt(line_cnt), .overflow(overflow),
      .clr_ovf(clr_ovf)
   );

   always @(negedge clk) if (pix_valid) n_valid++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      pixdata = b;
      pclk = 1'b1; tick(3);
      pclk = 1'b0; tick(3);
   endtask

   task automatic send_pix(input logic [15:0] w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic frame_start();
      vsync = 1'b1; tick(4);
      vsync = 1'b0; tick(4);
   endtask

   task automatic do_reset();
      {pclk, href, vsync, serck, clr_ovf} = '0;
      rst_n = 1'b0; tick(2);
      rst_n = 1'b1; tick(2);
   endtask

   initial begin
      int          base;
      logic [11:0] word;
      logic [11:0] exp_m3;

      // Reset values
      tick(3);
      check("rst_ser_out", ser_out, 0);
      check("rst_ser_busy", ser_busy, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_pix_data", pix_data, 0);
      check("rst_line_cnt", line_cnt, 0);
      check("rst_overflow", overflow, 0);

      // Raw pixel, then reset in the middle of a line
      rst_n = 1'b1; tick(2);
      frame_start();
      href = 1'b1; tick(4);
      base = n_valid;
      send_pix(16'h1234);
      check("raw_pix_data", pix_data, 12'h234);
      check("raw_valid_cnt", n_valid - base, 1);
      check("raw_busy_after_pop", ser_busy, 1);
      check("raw_start_bit", ser_out, 1);
      send_byte(8'h56);
      rst_n = 1'b0; tick(1);
      check("midrst_busy", ser_busy, 0);
      check("midrst_pix_data", pix_data, 0);
      check("midrst_ser_out", ser_out, 0);
      rst_n = 1'b1; tick(2);
      base = n_valid;
      send_pix(16'hABCD);
      send_pix(16'hABCD);
      check("midrst_no_valid_before_vsync", n_valid - base, 0);
      href = 1'b0; tick(4);
      check("midrst_line_cnt", line_cnt, 0);

      // RGB565 -> RGB444, two lines of four pixels
      do_reset();
      mode = 2'd1;
      frame_start();
      base = n_valid;
      for (int l = 0; l < 2; l++) begin
         href = 1'b1; tick(4);
         for (int p = 0; p < 4; p++) send_pix(16'hF81F);
         href = 1'b0; tick(4);
      end
      check("m1_pix_data", pix_data, 12'hF0F);
      check("m1_valid_cnt", n_valid - base, 8);
      check("m1_line_cnt", line_cnt, 2);
      vsync = 1'b1; tick(4);
      check("m1_line_cnt_cleared", line_cnt, 0);

      // Channel interleave; then raw and mode 3 within the same line
      do_reset();
      mode = 2'd2;
      frame_start();
      href = 1'b1; tick(4);
      send_pix(16'h0800); check("m2_p11", pix_data, 12'h800);
      send_pix(16'h0002); check("m2_p1", pix_data, 12'h010);
      send_pix(16'h0040); check("m2_p6", pix_data, 12'h004);
      send_pix(16'h0008); check("m2_p3", pix_data, 12'h002);
      mode = 2'd0;
      send_pix(16'hABCD); check("m0_raw", pix_data, 12'hBCD);
      mode = 2'd3;
`ifdef CAM_TEST_PATTERN_EN
      exp_m3 = 12'h005;
`else
      exp_m3 = 12'h234;
`endif
      send_pix(16'h1234); check("m3", pix_data, exp_m3);
      href = 1'b0; tick(4);

      // decim=1: keep every 2nd pixel, counter restarts each line
      do_reset();
      mode = 2'd0;
      decim = 3'd1;
      frame_start();
      href = 1'b1; tick(4);
      base = n_valid;
      for (int p = 1; p <= 3; p++) send_pix(16'(p));
      check("dec_l1_cnt", n_valid - base, 2);
      check("dec_l1_last", pix_data, 12'h003);
      href = 1'b0; tick(4);
      href = 1'b1; tick(4);
      base = n_valid;
      send_pix(16'h0010);
      check("dec_restart", pix_data, 12'h010);
      for (int p = 1; p < 8; p++) send_pix(16'h0010 + 16'(p));
      check("dec_l2_cnt", n_valid - base, 4);
      check("dec_l2_last", pix_data, 12'h016);
      href = 1'b0; tick(4);
      decim = 3'd0;

      // Overflow: one word sits in the shifter, so 17 pixels fit and the 18th overflows
      do_reset();
      mode = 2'd1;
      frame_start();
      href = 1'b1; tick(4);
      for (int p = 0; p < 17; p++) send_pix(16'hF81F);
      check("ovf_at_17", overflow, 0);
      send_pix(16'hF81F);
      check("ovf_at_18", overflow, 1);
      send_pix(16'hF81F);
      send_pix(16'hF81F);
      href = 1'b0; tick(4);
      check("ovf_sticky", overflow, 1);
      clr_ovf = 1'b1; tick(1);
      clr_ovf = 1'b0; tick(1);
      check("ovf_cleared", overflow, 0);

      // Serial frame: start bit then 0xF0F MSB first
      check("ser_start", ser_out, 1);
      word = '0;
      for (int i = 0; i < 12; i++) begin
         serck = 1'b1; tick(3);
         word = {word[10:0], ser_out};
         serck = 1'b0; tick(3);
      end
      check("ser_word", word, 12'hF0F);
      serck = 1'b1; tick(3);
      check("ser_end_out", ser_out, 0);
      check("ser_end_busy", ser_busy, 0);
      serck = 1'b0; tick(3);
      check("ser_next_pop", ser_busy, 1);

      // vsync rising mid-pixel discards the partial pixel
      do_reset();
      mode = 2'd0;
      frame_start();
      href = 1'b1; tick(4);
      base = n_valid;
      send_byte(8'h77);
      vsync = 1'b1; tick(4);
      send_pix(16'h0102);
      check("vs_abort_no_valid", n_valid - base, 0);
      vsync = 1'b0; tick(4);
      send_pix(16'h0A0B);
      check("vs_resume_cnt", n_valid - base, 1);
      check("vs_resume_data", pix_data, 12'hA0B);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
